// File: rtl/switch_mcu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with PC update and halt.
// Optional fetch watchdog enabled by defining SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN.
module switch_mcu_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_start,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  output logic [31:0] out_inst,
  output logic [3:0]  out_cycle_cnt,
  input  logic        in_mem_op,
  input  logic        in_mem_done,
  input  logic        in_redirect,
  input  logic [31:0] in_redirect_pc,
  input  logic        in_halt,
  output logic [31:0] out_pc,
  output logic        out_wb_en,
  output logic        out_busy,
  output logic        out_halted,
  output logic        out_fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Redirect targets are forced word-aligned, so the low bits are never consumed.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^in_redirect_pc[1:0];

`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(FETCH_TIMEOUT);
  logic [7:0] tmo_q, tmo_d;
  logic       fault_q, fault_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^8'(FETCH_TIMEOUT);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_start) begin
          state_d = FETCH;
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end
      end
      FETCH: begin
        // An ack always beats the watchdog, even on the limit cycle.
        if (in_imem_ack) begin
          inst_d  = in_imem_rdata;
          state_d = DECODE;
        end
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q + 8'd1 == TMO_LIMIT) begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end
`endif
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = in_mem_op ? MEM : WB;
      MEM: begin
        if (in_mem_done) state_d = WB;
      end
      WB: begin
        if (in_halt) begin
          state_d = HALT;
        end else begin
          pc_d    = in_redirect ? {in_redirect_pc[31:2], 2'b00} : pc_q + 32'd4;
          state_d = in_start ? FETCH : IDLE;
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
      tmo_q   <= 8'd0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Decoder phase index; the reset state maps to all-zero outputs.
  always_comb begin
    out_cycle_cnt = 4'd0;
    case (state_q)
      DECODE:  out_cycle_cnt = 4'd1;
      EXEC:    out_cycle_cnt = 4'd2;
      MEM:     out_cycle_cnt = 4'd3;
      WB:      out_cycle_cnt = 4'd4;
      default: out_cycle_cnt = 4'd0;
    endcase
  end

  assign out_imem_req  = (state_q == FETCH);
  assign out_imem_addr = pc_q;
  assign out_pc        = pc_q;
  assign out_inst      = inst_q;
  assign out_wb_en     = (state_q == WB);
  assign out_busy      = (state_q != IDLE) && (state_q != HALT);
  assign out_halted    = (state_q == HALT);
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
  assign out_fault     = fault_q;
`else
  assign out_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_switch_mcu_sequencer.sv
// Directed bench for switch_mcu_sequencer: fetch/decode/exec/mem/wb flow, PC update,
// halt, fetch watchdog (either build) and asynchronous reset.
module tb_switch_mcu_sequencer;

  logic        in_clk;
  logic        in_rst;
  logic        in_start;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic [31:0] out_inst;
  logic [3:0]  out_cycle_cnt;
  logic        in_mem_op;
  logic        in_mem_done;
  logic        in_redirect;
  logic [31:0] in_redirect_pc;
  logic        in_halt;
  logic [31:0] out_pc;
  logic        out_wb_en;
  logic        out_busy;
  logic        out_halted;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  switch_mcu_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (15)
  ) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_start       (in_start),
    .out_imem_req   (out_imem_req),
    .out_imem_addr  (out_imem_addr),
    .in_imem_ack    (in_imem_ack),
    .in_imem_rdata  (in_imem_rdata),
    .out_inst       (out_inst),
    .out_cycle_cnt  (out_cycle_cnt),
    .in_mem_op      (in_mem_op),
    .in_mem_done    (in_mem_done),
    .in_redirect    (in_redirect),
    .in_redirect_pc (in_redirect_pc),
    .in_halt        (in_halt),
    .out_pc         (out_pc),
    .out_wb_en      (out_wb_en),
    .out_busy       (out_busy),
    .out_halted     (out_halted),
    .out_fault      (out_fault)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One zero-wait instruction starting from a FETCH cycle; returns one edge after WB.
  task automatic runInst(input logic [31:0] rdata, input logic mem_op, input logic redirect,
                         input logic [31:0] rpc, input logic halt, input logic start_wb);
    in_imem_ack   = 1'b1;
    in_imem_rdata = rdata;
    in_mem_op     = mem_op;
    applyStimulus(1);
    in_imem_ack = 1'b0;
    checkOutput("run_dec_cnt", 32'(out_cycle_cnt), 32'd1);
    checkOutput("run_dec_inst", out_inst, rdata);
    applyStimulus(1);
    checkOutput("run_exec_cnt", 32'(out_cycle_cnt), 32'd2);
    applyStimulus(1);
    if (mem_op) begin
      in_mem_done = 1'b1;
      applyStimulus(1);
      in_mem_done = 1'b0;
    end
    checkOutput("run_wb_cnt", 32'(out_cycle_cnt), 32'd4);
    checkOutput("run_wb_en", 32'(out_wb_en), 32'd1);
    in_redirect    = redirect;
    in_redirect_pc = rpc;
    in_halt        = halt;
    in_start       = start_wb;
    applyStimulus(1);
    in_redirect = 1'b0;
    in_halt     = 1'b0;
    in_mem_op   = 1'b0;
  endtask

  initial begin
    in_rst = 1'b0; in_start = 1'b0; in_imem_ack = 1'b0; in_imem_rdata = 32'd0;
    in_mem_op = 1'b0; in_mem_done = 1'b0; in_redirect = 1'b0;
    in_redirect_pc = 32'd0; in_halt = 1'b0;
    $display("[TB] start");

    applyStimulus(2);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_addr", out_imem_addr, 32'h0);
    checkOutput("rst_inst", out_inst, 32'h0);
    checkOutput("rst_cnt", 32'(out_cycle_cnt), 32'd0);
    checkOutput("rst_req", 32'(out_imem_req), 32'd0);
    checkOutput("rst_busy", 32'(out_busy), 32'd0);
    checkOutput("rst_wb", 32'(out_wb_en), 32'd0);
    checkOutput("rst_halted", 32'(out_halted), 32'd0);
    checkOutput("rst_fault", 32'(out_fault), 32'd0);

    in_rst = 1'b1;
    applyStimulus(2);
    checkOutput("idle_hold_req", 32'(out_imem_req), 32'd0);
    checkOutput("idle_hold_busy", 32'(out_busy), 32'd0);

    // First instruction: zero-wait ack, no memory access.
    in_start = 1'b1;
    applyStimulus(1);
    checkOutput("f1_req", 32'(out_imem_req), 32'd1);
    checkOutput("f1_addr", out_imem_addr, 32'h0);
    checkOutput("f1_cnt", 32'(out_cycle_cnt), 32'd0);
    checkOutput("f1_busy", 32'(out_busy), 32'd1);
    in_imem_ack = 1'b1; in_imem_rdata = 32'h0000_0013;
    applyStimulus(1);
    in_imem_rdata = 32'hDEAD_BEEF;
    checkOutput("d1_cnt", 32'(out_cycle_cnt), 32'd1);
    checkOutput("d1_inst", out_inst, 32'h0000_0013);
    checkOutput("d1_req", 32'(out_imem_req), 32'd0);
    applyStimulus(1);
    in_imem_ack = 1'b0;
    checkOutput("e1_cnt", 32'(out_cycle_cnt), 32'd2);
    checkOutput("e1_inst_ack_ignored", out_inst, 32'h0000_0013);
    applyStimulus(1);
    checkOutput("w1_cnt", 32'(out_cycle_cnt), 32'd4);
    checkOutput("w1_wb_en", 32'(out_wb_en), 32'd1);
    checkOutput("w1_pc", out_pc, 32'h0);
    applyStimulus(1);
    checkOutput("f2_wb_en", 32'(out_wb_en), 32'd0);
    checkOutput("f2_pc", out_pc, 32'h4);
    checkOutput("f2_addr", out_imem_addr, 32'h4);
    checkOutput("f2_req", 32'(out_imem_req), 32'd1);

    // Memory instruction; in_mem_done before MEM is ignored, then done on 3rd MEM cycle.
    in_imem_ack = 1'b1; in_imem_rdata = 32'h0000_2003; in_mem_op = 1'b1;
    applyStimulus(1);
    in_imem_ack = 1'b0; in_mem_done = 1'b1;
    applyStimulus(1);
    checkOutput("m_exec_cnt", 32'(out_cycle_cnt), 32'd2);
    applyStimulus(1);
    in_mem_done = 1'b0;
    checkOutput("m_mem1_cnt", 32'(out_cycle_cnt), 32'd3);
    applyStimulus(1);
    checkOutput("m_mem2_cnt", 32'(out_cycle_cnt), 32'd3);
    applyStimulus(1);
    checkOutput("m_mem3_cnt", 32'(out_cycle_cnt), 32'd3);
    in_mem_done = 1'b1;
    applyStimulus(1);
    in_mem_done = 1'b0; in_mem_op = 1'b0;
    checkOutput("m_wb_cnt", 32'(out_cycle_cnt), 32'd4);
    in_redirect = 1'b1; in_redirect_pc = 32'h0000_0103;
    applyStimulus(1);
    in_redirect = 1'b0;
    checkOutput("redir_addr", out_imem_addr, 32'h0000_0100);

    // Redirect alignment to the top word, then sequential wrap to zero.
    runInst(32'h0000_0013, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    checkOutput("top_addr", out_imem_addr, 32'hFFFF_FFFC);
    runInst(32'h0000_0093, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_addr", out_imem_addr, 32'h0);

    // Dropping in_start mid-instruction finishes it, then stops in IDLE.
    in_imem_ack = 1'b1; in_imem_rdata = 32'h0000_0113;
    applyStimulus(1);
    in_imem_ack = 1'b0; in_start = 1'b0;
    applyStimulus(1);
    checkOutput("stop_exec_cnt", 32'(out_cycle_cnt), 32'd2);
    checkOutput("stop_exec_busy", 32'(out_busy), 32'd1);
    applyStimulus(1);
    checkOutput("stop_wb_en", 32'(out_wb_en), 32'd1);
    applyStimulus(1);
    checkOutput("stop_idle_busy", 32'(out_busy), 32'd0);
    checkOutput("stop_idle_pc", out_pc, 32'h4);
    applyStimulus(2);
    checkOutput("stop_idle_req", 32'(out_imem_req), 32'd0);
    in_start = 1'b1;
    applyStimulus(1);
    checkOutput("resume_addr", out_imem_addr, 32'h4);
    checkOutput("resume_req", 32'(out_imem_req), 32'd1);

    // Halt beats redirect; PC frozen and no further fetch requests.
    runInst(32'h0000_0073, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    checkOutput("halt_halted", 32'(out_halted), 32'd1);
    checkOutput("halt_pc", out_pc, 32'h4);
    checkOutput("halt_busy", 32'(out_busy), 32'd0);
    checkOutput("halt_cnt", 32'(out_cycle_cnt), 32'd0);
    in_imem_ack = 1'b1;
    applyStimulus(5);
    in_imem_ack = 1'b0;
    checkOutput("halt_stay", 32'(out_halted), 32'd1);
    checkOutput("halt_no_req", 32'(out_imem_req), 32'd0);
    checkOutput("halt_pc_hold", out_pc, 32'h4);

    in_rst = 1'b0;
    #1;
    checkOutput("halt_rst_halted", 32'(out_halted), 32'd0);
    checkOutput("halt_rst_pc", out_pc, 32'h0);
    applyStimulus(1);
    in_rst = 1'b1;
    applyStimulus(1);
    checkOutput("post_rst_addr", out_imem_addr, 32'h0);
    checkOutput("post_rst_req", 32'(out_imem_req), 32'd1);

    // Fetch without ack: watchdog fault in one build, indefinite wait in the other.
`ifdef SWITCH_MCU_SEQ_FETCH_TIMEOUT_EN
    applyStimulus(14);
    checkOutput("tmo_pre_req", 32'(out_imem_req), 32'd1);
    checkOutput("tmo_pre_fault", 32'(out_fault), 32'd0);
    applyStimulus(1);
    checkOutput("tmo_fault", 32'(out_fault), 32'd1);
    checkOutput("tmo_halted", 32'(out_halted), 32'd1);
    checkOutput("tmo_req", 32'(out_imem_req), 32'd0);
`else
    applyStimulus(100);
    checkOutput("wait_req", 32'(out_imem_req), 32'd1);
    checkOutput("wait_fault", 32'(out_fault), 32'd0);
    checkOutput("wait_busy", 32'(out_busy), 32'd1);
    checkOutput("wait_cnt", 32'(out_cycle_cnt), 32'd0);
`endif

    // Asynchronous reset in the middle of MEM.
    in_rst = 1'b0;
    applyStimulus(1);
    in_rst = 1'b1;
    applyStimulus(1);
    runInst(32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("pre_mem_addr", out_imem_addr, 32'h4);
    in_imem_ack = 1'b1; in_imem_rdata = 32'h0000_A023; in_mem_op = 1'b1;
    applyStimulus(1);
    in_imem_ack = 1'b0;
    applyStimulus(2);
    checkOutput("mid_mem_cnt", 32'(out_cycle_cnt), 32'd3);
    #2 in_rst = 1'b0;
    #1;
    checkOutput("arst_pc", out_pc, 32'h0);
    checkOutput("arst_addr", out_imem_addr, 32'h0);
    checkOutput("arst_inst", out_inst, 32'h0);
    checkOutput("arst_cnt", 32'(out_cycle_cnt), 32'd0);
    checkOutput("arst_busy", 32'(out_busy), 32'd0);
    checkOutput("arst_wb", 32'(out_wb_en), 32'd0);
    checkOutput("arst_req", 32'(out_imem_req), 32'd0);
    checkOutput("arst_fault", 32'(out_fault), 32'd0);
    applyStimulus(1);
    in_rst = 1'b1; in_mem_op = 1'b0;
    applyStimulus(1);
    checkOutput("arst_resume_addr", out_imem_addr, 32'h0);
    checkOutput("arst_resume_req", 32'(out_imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
